// File: rtl/bp_pkg.sv
// Shared types and counter constants for the BTB branch predictor.
// Default sizes here match the core; the predictor re-derives widths from its own parameters.
package bp_pkg;

  localparam int unsigned BP_DW      = 32;
  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_CTR_W   = 2;
  localparam int unsigned BP_IDX     = $clog2(BP_ENTRIES);

  typedef logic [BP_CTR_W-1:0] ctr_t;

  typedef struct packed {
    logic                      valid;
    logic [BP_DW-BP_IDX-3:0]   tag;
    logic [BP_DW-1:0]          target;
    ctr_t                      ctr;
  } btb_entry_t;

  // Weak-taken: MSB set, rest clear. Weak-not-taken: MSB clear, rest set.
  function automatic logic [31:0] ctr_weak_t(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic logic [31:0] ctr_weak_nt(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bp_if.sv
// Fetch-lookup and EX-resolution signals between the pipeline and the branch predictor.
interface bp_if #(parameter int unsigned DATA_WIDTH = 32);

  logic [DATA_WIDTH-1:0] PCF;
  logic                  PredTakenF;
  logic [DATA_WIDTH-1:0] PredTargetF;
  logic                  UpdateE;
  logic                  JumpE;
  logic [DATA_WIDTH-1:0] PCE;
  logic                  TakenE;
  logic [DATA_WIDTH-1:0] TargetE;
  logic                  PredTakenE;
  logic [DATA_WIDTH-1:0] PredTargetE;
  logic                  MispredictE;
  logic [DATA_WIDTH-1:0] RedirectPCE;
  logic [31:0]           BranchCnt;
  logic [31:0]           MissCnt;

  modport slave (
    input  PCF, UpdateE, JumpE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCnt, MissCnt
  );

  modport master (
    output PCF, UpdateE, JumpE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCnt, MissCnt
  );

endinterface

// File: rtl/bp_sat_ctr.sv
// Next-state for an n-bit saturating direction counter (force-max for unconditional jumps).
module bp_sat_ctr #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] ctr_i,
  input  logic         inc_i,
  input  logic         force_max_i,
  output logic [W-1:0] ctr_o
);

  localparam logic [W-1:0] MAX = '1;

  always_comb begin
    ctr_o = ctr_i;
    if (force_max_i)
      ctr_o = MAX;
    else if (inc_i) begin
      if (ctr_i != MAX) ctr_o = ctr_i + W'(1);
    end else if (ctr_i != '0)
      ctr_o = ctr_i - W'(1);
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating counters: async lookup at IF, update and
// misprediction detection at EX, plus saturating branch/miss perf counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = BP_DW,
  parameter int unsigned ENTRIES    = BP_ENTRIES,
  parameter int unsigned CTR_WIDTH  = BP_CTR_W
) (
  input logic clk,
  input logic rst,
  bp_if.slave bus
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS = DATA_WIDTH - IDX_BITS - 2;

  typedef logic [CTR_WIDTH-1:0] lctr_t;
  typedef struct packed {
    logic                  valid;
    logic [TAG_BITS-1:0]   tag;
    logic [DATA_WIDTH-1:0] target;
    lctr_t                 ctr;
  } entry_t;

  localparam lctr_t  WEAK_T    = lctr_t'(ctr_weak_t(CTR_WIDTH));
  localparam lctr_t  WEAK_NT   = lctr_t'(ctr_weak_nt(CTR_WIDTH));
  localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};

  entry_t btb_q [ENTRIES];

  // Fetch-side lookup: purely combinational off the flop array.
  logic [IDX_BITS-1:0] idx_f;
  logic [TAG_BITS-1:0] tag_f;
  entry_t              ent_f;
  logic                hit_f;

  assign idx_f = bus.PCF[IDX_BITS+1:2];
  assign tag_f = bus.PCF[DATA_WIDTH-1:IDX_BITS+2];
  assign ent_f = btb_q[idx_f];
  assign hit_f = ent_f.valid && (ent_f.tag == tag_f);

  assign bus.PredTakenF  = hit_f & ent_f.ctr[CTR_WIDTH-1];
  assign bus.PredTargetF = hit_f ? ent_f.target : '0;

  // Resolution side.
  logic [IDX_BITS-1:0] idx_e;
  logic [TAG_BITS-1:0] tag_e;
  entry_t              ent_e;
  entry_t              ent_d;
  logic                hit_e;
  logic                wr_en;
  lctr_t               ctr_nxt;

  assign idx_e = bus.PCE[IDX_BITS+1:2];
  assign tag_e = bus.PCE[DATA_WIDTH-1:IDX_BITS+2];
  assign ent_e = btb_q[idx_e];
  assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

  bp_sat_ctr #(.W(CTR_WIDTH)) u_sat_ctr (
    .ctr_i       (ent_e.ctr),
    .inc_i       (bus.TakenE),
    .force_max_i (bus.JumpE),
    .ctr_o       (ctr_nxt)
  );

  assign bus.MispredictE = bus.UpdateE &
                           ((bus.TakenE != bus.PredTakenE) |
                            (bus.TakenE & bus.PredTakenE & (bus.TargetE != bus.PredTargetE)));
  assign bus.RedirectPCE = bus.TakenE ? bus.TargetE : bus.PCE + DATA_WIDTH'(4);

  always_comb begin
    wr_en = 1'b0;
    ent_d = ent_e;
    if (bus.UpdateE) begin
      if (hit_e) begin
        wr_en     = 1'b1;
        ent_d.ctr = ctr_nxt;
        if (bus.TakenE) ent_d.target = bus.TargetE;
      end else if (bus.TakenE) begin
        // Allocation overwrites whatever aliased into this slot.
        wr_en        = 1'b1;
        ent_d.valid  = 1'b1;
        ent_d.tag    = tag_e;
        ent_d.target = bus.TargetE;
        ent_d.ctr    = bus.JumpE ? '1 : WEAK_T;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) btb_q[i] <= RST_ENTRY;
    end else if (wr_en) begin
      btb_q[idx_e] <= ent_d;
    end
  end

  // Perf counters.
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (bus.UpdateE && branch_cnt_q != '1)     branch_cnt_d = branch_cnt_q + 32'd1;
    if (bus.MispredictE && miss_cnt_q != '1)   miss_cnt_d   = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.BranchCnt = branch_cnt_q;
  assign bus.MissCnt   = miss_cnt_q;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bus.PCF[1:0], bus.PCE[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Randomised + directed bench: a queue-based scoreboard fed by an abstract BTB model.
module tb_branch_predictor;

  localparam int DW   = 32;
  localparam int ENT  = 16;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int CHALF = 1 << (CW - 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bp_if #(.DATA_WIDTH(DW)) bus ();

  branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(ENT), .CTR_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          pt;
    logic [31:0] ptgt;
    bit          misp;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Reference model: one slot per index, counter kept as a plain integer.
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  logic [31:0] m_bc, m_mc;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % ENT;
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * ENT);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = CHALF - 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic m_pred(input logic [31:0] pc, output bit pt, output logic [31:0] tg);
    bit h;
    h  = m_hit(pc);
    pt = h && (m_ctr[idx_of(pc)] >= CHALF);
    tg = h ? m_tgt[idx_of(pc)] : 32'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; the model is advanced at the following edge.
  task automatic cyc(input bit r, input bit push, input bit upd, input bit jmp,
                     input logic [31:0] pcf, input logic [31:0] pce, input bit tk,
                     input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    exp_t e;
    bit   mp;
    int   ix;
    rst = r;
    bus.PCF = pcf; bus.UpdateE = upd; bus.JumpE = jmp; bus.PCE = pce;
    bus.TakenE = tk; bus.TargetE = tg; bus.PredTakenE = pt; bus.PredTargetE = ptg;
    m_pred(pcf, e.pt, e.ptgt);
    mp      = upd && ((tk != pt) || (tk && pt && tg != ptg));
    e.misp  = mp;
    e.redir = tk ? tg : pce + 32'd4;
    e.bc    = m_bc;
    e.mc    = m_mc;
    if (push) sbq.push_back(e);
    @(posedge clk);
    if (r) m_reset();
    else if (upd) begin
      if (m_bc != 32'hFFFF_FFFF) m_bc++;
      if (mp && m_mc != 32'hFFFF_FFFF) m_mc++;
      ix = idx_of(pce);
      if (m_hit(pce)) begin
        if (jmp)     m_ctr[ix] = CMAX;
        else if (tk) m_ctr[ix] = (m_ctr[ix] < CMAX) ? m_ctr[ix] + 1 : CMAX;
        else         m_ctr[ix] = (m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0;
        if (tk) m_tgt[ix] = tg;
      end else if (tk) begin
        m_valid[ix] = 1; m_tag[ix] = tag_of(pce); m_tgt[ix] = tg;
        m_ctr[ix] = jmp ? CMAX : CHALF;
      end
    end
    #1;
  endtask

  task automatic look(input logic [31:0] pcf);
    cyc(0, 1, 0, 0, pcf, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // Monitor: outputs are combinational, so compare once per cycle mid-period.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("PredTakenF",  {31'd0, bus.PredTakenF},  {31'd0, e.pt});
        chk("PredTargetF", bus.PredTargetF,          e.ptgt);
        chk("MispredictE", {31'd0, bus.MispredictE}, {31'd0, e.misp});
        if (e.misp) chk("RedirectPCE", bus.RedirectPCE, e.redir);
        chk("BranchCnt",   bus.BranchCnt,            e.bc);
        chk("MissCnt",     bus.MissCnt,              e.mc);
      end
    end
  end

  initial begin
    bit          rpt;
    logic [31:0] rtg, pce, pcf, tg;
    bit          tk, jmp, upd, r;
    m_reset();
    rst = 1'b1;
    bus.PCF = 0; bus.UpdateE = 0; bus.JumpE = 0; bus.PCE = 0;
    bus.TakenE = 0; bus.TargetE = 0; bus.PredTakenE = 0; bus.PredTargetE = 0;
    @(posedge clk); #1;
    cyc(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    cyc(1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);

    look(32'h100);                                                  // reset state
    cyc(0, 1, 1, 0, 32'h0, 32'h100, 1, 32'h80, 0, 32'h0);           // cold taken
    look(32'h100);
    cyc(0, 1, 1, 0, 32'h0, 32'h100, 0, 32'h0, 1, 32'h80);           // saturate down
    look(32'h100);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 32'h100, 32'h100, 0, 32'h0, 0, 32'h0);
    cyc(0, 1, 1, 0, 32'h0, 32'h100, 1, 32'h80, 0, 32'h80);
    look(32'h100);
    cyc(0, 1, 1, 0, 32'h0, 32'h140, 1, 32'h300, 0, 32'h0);          // alias replace
    look(32'h100);
    cyc(0, 1, 1, 1, 32'h0, 32'h140, 1, 32'h300, 1, 32'h300);        // jump forces max
    look(32'h140);
    cyc(0, 1, 1, 0, 32'h200, 32'h200, 1, 32'h400, 0, 32'h0);        // same-cycle
    look(32'h200);
    cyc(0, 1, 1, 1, 32'h0, 32'h300, 1, 32'h80, 0, 32'h0);
    look(32'h300);
    cyc(0, 1, 1, 1, 32'h300, 32'h300, 1, 32'h90, 1, 32'h80);        // target mismatch
    look(32'h300);
    cyc(1, 1, 1, 0, 32'h300, 32'h300, 1, 32'h44, 0, 32'h0);         // reset beats update
    look(32'h300);
    look(32'h140);

    for (int n = 0; n < 600; n++) begin
      pce = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      pcf = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) pcf = pce;
      upd = ($urandom_range(0, 3) != 0);
      jmp = ($urandom_range(0, 5) == 0);
      tk  = jmp ? 1'b1 : $urandom_range(0, 1);
      tg  = $urandom_range(0, 7) << 4;
      r   = ($urandom_range(0, 199) == 0);
      m_pred(pce, rpt, rtg);
      if ($urandom_range(0, 9) < 3) begin
        rpt = $urandom_range(0, 1);
        rtg = $urandom_range(0, 7) << 4;
      end
      cyc(r, 1, upd, jmp, pcf, pce, tk, tg, rpt, rtg);
    end

    bus.UpdateE = 0;
    for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
